// File: rtl/conv_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler, the layer controller, the window loader,
// the conv datapath and the downstream pixel consumer.
interface conv_frame_scheduler_if #(
    parameter int CNT_W = 5,
    parameter int ACC_W = 27,
    parameter int OUT_W = 9
);
    logic                    go;
    logic                    abort;
    logic                    win_req;
    logic [CNT_W-1:0]        win_row;
    logic [CNT_W-1:0]        win_col;
    logic                    win_ack;
    logic                    conv_start;
    logic                    conv_done;
    logic signed [ACC_W-1:0] conv_result;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [CNT_W-1:0]        out_row;
    logic [CNT_W-1:0]        out_col;
    logic                    busy;
    logic                    frame_done;
    logic                    err_timeout;

    modport master (
        input  go, abort, win_ack, conv_done, conv_result, out_ready,
        output win_req, win_row, win_col, conv_start, out_valid, out_data,
               out_row, out_col, busy, frame_done, err_timeout
    );

    modport slave (
        output go, abort, win_ack, conv_done, conv_result, out_ready,
        input  win_req, win_row, win_col, conv_start, out_valid, out_data,
               out_row, out_col, busy, frame_done, err_timeout
    );
endinterface

// File: rtl/conv_frame_scheduler.sv
// Walks one output feature map pixel by pixel: window load, conv pass, result capture,
// requantisation (shift / optional ReLU / saturate) and tagged streaming of the pixel.
module conv_frame_scheduler #(
    parameter int OUT_ROWS = 24,
    parameter int OUT_COLS = 24,
    parameter int CNT_W    = 5,
    parameter int ACC_W    = 27,
    parameter int OUT_W    = 9,
    parameter int SHIFT    = 8,
    parameter int RELU     = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_frame_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_EMIT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam int                      WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]         WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]        LAST_ROW = CNT_W'(OUT_ROWS - 1);
    localparam logic [CNT_W-1:0]        LAST_COL = CNT_W'(OUT_COLS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        row_q, row_d;
    logic [CNT_W-1:0]        col_q, col_d;
    logic [WD_W-1:0]         wdog_q, wdog_d;
    logic signed [ACC_W-1:0] cap_q, cap_d;
    logic signed [OUT_W-1:0] odata_q, odata_d;
    logic                    err_q, err_d;

    // Arithmetic shift keeps the sign; ReLU is applied before the clamp so it only ever widens toward 0.
    function automatic logic signed [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        logic signed [OUT_W-1:0] r;
        s = acc >>> SHIFT;
        if (RELU != 0 && s[ACC_W-1]) begin
            s = '0;
        end
        if (s > SAT_MAX) begin
            r = SAT_MAX[OUT_W-1:0];
        end else if (s < SAT_MIN) begin
            r = SAT_MIN[OUT_W-1:0];
        end else begin
            r = s[OUT_W-1:0];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            wdog_q  <= '0;
            cap_q   <= '0;
            odata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wdog_q  <= wdog_d;
            cap_q   <= cap_d;
            odata_q <= odata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        wdog_d  = wdog_q;
        cap_d   = cap_q;
        odata_d = odata_q;
        err_d   = err_q;
        // Abort outranks every other transition, including a same-cycle done or accept.
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.go) begin
                        state_d = S_LOAD;
                        row_d   = '0;
                        col_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.win_ack) begin
                        state_d = S_RUN;
                        wdog_d  = '0;
                    end
                end
                S_RUN: begin
                    if (bus.conv_done) begin
                        cap_d   = bus.conv_result;
                        state_d = S_DRAIN;
                    end else if (wdog_q == WD_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    odata_d = requant(cap_q);
                    state_d = S_EMIT;
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            if (row_q == LAST_ROW) begin
                                state_d = S_FIN;
                            end else begin
                                row_d   = row_q + 1'b1;
                                state_d = S_LOAD;
                            end
                        end else begin
                            col_d   = col_q + 1'b1;
                            state_d = S_LOAD;
                        end
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.win_req     = 1'b0;
        bus.conv_start  = 1'b0;
        bus.out_valid   = 1'b0;
        bus.frame_done  = 1'b0;
        bus.busy        = (state_q != S_IDLE);
        bus.err_timeout = err_q;
        bus.win_row     = '0;
        bus.win_col     = '0;
        bus.out_row     = '0;
        bus.out_col     = '0;
        bus.out_data    = '0;
        if (state_q != S_IDLE) begin
            bus.win_row = row_q;
            bus.win_col = col_q;
        end
        case (state_q)
            S_LOAD: bus.win_req    = 1'b1;
            S_RUN:  bus.conv_start = 1'b1;
            S_EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = odata_q;
                bus.out_row   = row_q;
                bus.out_col   = col_q;
            end
            S_FIN:  bus.frame_done = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Bench for conv_frame_scheduler: a 2x2 ReLU instance for frame sequencing and a 1x1 bypass instance.
module tb_conv_frame_scheduler;
    localparam int CNT_W = 5;
    localparam int ACC_W = 27;
    localparam int OUT_W = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int fd_cnt = 0;
    int frame_vals[4];

    conv_frame_scheduler_if #(.CNT_W(CNT_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) m_if();
    conv_frame_scheduler_if #(.CNT_W(CNT_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) n_if();

    conv_frame_scheduler #(.OUT_ROWS(2), .OUT_COLS(2), .CNT_W(CNT_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
                           .SHIFT(8), .RELU(1), .TIMEOUT(64))
        u_dut (.clk(clk), .reset(reset), .bus(m_if));

    conv_frame_scheduler #(.OUT_ROWS(1), .OUT_COLS(1), .CNT_W(CNT_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
                           .SHIFT(8), .RELU(0), .TIMEOUT(64))
        u_nr (.clk(clk), .reset(reset), .bus(n_if));

    always @(negedge clk) if (m_if.frame_done === 1'b1) fd_cnt++;

    // Reference requantiser: floor-divide by 2^8, optional ReLU, clamp to 9-bit signed.
    function automatic int ref_requant(input longint v, input bit relu);
        longint s;
        if (v >= 0) s = v / 256;
        else        s = -((-v + 255) / 256);
        if (relu && s < 0) s = 0;
        if (s > 255)  s = 255;
        if (s < -256) s = -256;
        return int'(s);
    endfunction

    function automatic int rand_acc();
        return int'($urandom_range(0, (1 << 27) - 1)) - (1 << 26);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_frame();
        m_if.go = 1'b1;
        tick();
        m_if.go = 1'b0;
    endtask

    task automatic do_pixel(input int r, input int c, input int res,
                            input int ack_dly, input int done_dly, input int ready_dly);
        int n;
        int exp;
        n = 0;
        while (m_if.win_req !== 1'b1 && n < 20) begin tick(); n++; end
        tests++;
        if (m_if.win_req !== 1'b1) begin
            fails++; $display("FAIL win_req_wait: win_req=%b required 1", m_if.win_req); return;
        end
        tests++;
        if (m_if.win_row !== CNT_W'(r) || m_if.win_col !== CNT_W'(c)) begin
            fails++; $display("FAIL win_tag: got (%0d,%0d) required (%0d,%0d)", m_if.win_row, m_if.win_col, r, c);
        end
        repeat (ack_dly) tick();
        m_if.win_ack = 1'b1;
        tick();
        m_if.win_ack = 1'b0;
        tests++;
        if (m_if.conv_start !== 1'b1 || m_if.win_req !== 1'b0) begin
            fails++; $display("FAIL run_entry: conv_start=%b win_req=%b required 1/0", m_if.conv_start, m_if.win_req);
        end
        repeat (done_dly - 1) tick();
        m_if.conv_done = 1'b1;
        m_if.conv_result = ACC_W'(res);
        tick();
        m_if.conv_done = 1'b0;
        m_if.conv_result = ACC_W'($urandom);
        tests++;
        if (m_if.conv_start !== 1'b0 || m_if.out_valid !== 1'b0) begin
            fails++; $display("FAIL drain_gap: conv_start=%b out_valid=%b required 0/0", m_if.conv_start, m_if.out_valid);
        end
        tick();
        exp = ref_requant(res, 1'b1);
        for (int i = 0; i < ready_dly; i++) begin
            tests++;
            if (m_if.out_valid !== 1'b1 || int'(m_if.out_data) !== exp || m_if.out_row !== CNT_W'(r) ||
                m_if.out_col !== CNT_W'(c) || m_if.conv_start !== 1'b0 || m_if.win_req !== 1'b0) begin
                fails++;
                $display("FAIL emit_hold: v=%b data=%0d tag=(%0d,%0d) start=%b req=%b required 1 %0d (%0d,%0d) 0 0",
                         m_if.out_valid, m_if.out_data, m_if.out_row, m_if.out_col, m_if.conv_start,
                         m_if.win_req, exp, r, c);
            end
            tick();
        end
        tests++;
        if (m_if.out_valid !== 1'b1 || int'(m_if.out_data) !== exp ||
            m_if.out_row !== CNT_W'(r) || m_if.out_col !== CNT_W'(c)) begin
            fails++;
            $display("FAIL emit_pixel: v=%b data=%0d tag=(%0d,%0d) required 1 %0d (%0d,%0d) for result %0d",
                     m_if.out_valid, m_if.out_data, m_if.out_row, m_if.out_col, exp, r, c, res);
        end
        m_if.out_ready = 1'b1;
        tick();
        m_if.out_ready = 1'b0;
    endtask

    task automatic run_frame(input bit rnd, input int first_ready);
        int fd0;
        fd0 = fd_cnt;
        start_frame();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                do_pixel(r, c, frame_vals[r*2+c],
                         rnd ? int'($urandom_range(0, 2)) : 0,
                         rnd ? int'($urandom_range(1, 40)) : 22,
                         (r == 0 && c == 0) ? first_ready : (rnd ? int'($urandom_range(0, 3)) : 0));
            end
        end
        tests++;
        if (m_if.frame_done !== 1'b1 || m_if.busy !== 1'b1) begin
            fails++; $display("FAIL fin_pulse: frame_done=%b busy=%b required 1/1", m_if.frame_done, m_if.busy);
        end
        tick();
        tests++;
        if (m_if.frame_done !== 1'b0 || m_if.busy !== 1'b0 || fd_cnt - fd0 !== 1) begin
            fails++;
            $display("FAIL frame_end: frame_done=%b busy=%b pulses=%0d required 0/0/1",
                     m_if.frame_done, m_if.busy, fd_cnt - fd0);
        end
    endtask

    task automatic nr_pixel(input int res);
        int exp;
        n_if.go = 1'b1;
        tick();
        n_if.go = 1'b0;
        tests++;
        if (n_if.win_req !== 1'b1) begin
            fails++; $display("FAIL nr_load: win_req=%b required 1", n_if.win_req);
        end
        n_if.win_ack = 1'b1;
        tick();
        n_if.win_ack = 1'b0;
        repeat (3) tick();
        n_if.conv_done = 1'b1;
        n_if.conv_result = ACC_W'(res);
        tick();
        n_if.conv_done = 1'b0;
        tick();
        exp = ref_requant(res, 1'b0);
        tests++;
        if (n_if.out_valid !== 1'b1 || int'(n_if.out_data) !== exp || n_if.out_row !== '0 || n_if.out_col !== '0) begin
            fails++;
            $display("FAIL nr_emit: v=%b data=%0d required 1 %0d for result %0d", n_if.out_valid, n_if.out_data, exp, res);
        end
        n_if.out_ready = 1'b1;
        tick();
        n_if.out_ready = 1'b0;
        tests++;
        if (n_if.frame_done !== 1'b1) begin
            fails++; $display("FAIL nr_fin: frame_done=%b required 1", n_if.frame_done);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests++;
        if ({m_if.win_req, m_if.conv_start, m_if.out_valid, m_if.busy, m_if.frame_done, m_if.err_timeout,
             m_if.win_row, m_if.win_col, m_if.out_row, m_if.out_col, m_if.out_data} !== '0) begin
            fails++; $display("FAIL reset_outputs: a nonzero output during reset, required all 0");
        end
        reset = 1'b0;
        tick();
        tests++;
        if (m_if.busy !== 1'b0 || n_if.busy !== 1'b0 || m_if.err_timeout !== 1'b0) begin
            fails++; $display("FAIL reset_idle: busy=%b/%b err=%b required 0", m_if.busy, n_if.busy, m_if.err_timeout);
        end
    endtask

    task automatic test_frame();
        for (int k = 0; k < 4; k++) frame_vals[k] = 'h100 * (k + 1);
        run_frame(1'b0, 0);
    endtask

    task automatic test_requant();
        frame_vals[0] = 'h7FFFF;
        frame_vals[1] = -'h30000;
        frame_vals[2] = 'h1FF;
        frame_vals[3] = rand_acc();
        run_frame(1'b0, 0);
    endtask

    task automatic test_relu_bypass();
        nr_pixel(-'h30000);
        nr_pixel('h7FFFF);
        nr_pixel(-'h1FF);
        nr_pixel(rand_acc());
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 4; k++) frame_vals[k] = rand_acc();
        run_frame(1'b0, 10);
    endtask

    task automatic test_timeout();
        int n;
        bit ov_seen;
        start_frame();
        m_if.win_ack = 1'b1;
        tick();
        m_if.win_ack = 1'b0;
        n = 0;
        ov_seen = 1'b0;
        while (m_if.conv_start === 1'b1 && n < 100) begin
            n++;
            if (m_if.out_valid !== 1'b0) ov_seen = 1'b1;
            tick();
        end
        tests++;
        if (n !== 64) begin
            fails++; $display("FAIL timeout_len: run cycles=%0d required 64", n);
        end
        tests++;
        if (m_if.err_timeout !== 1'b1 || m_if.busy !== 1'b0 || m_if.out_valid !== 1'b0 || ov_seen) begin
            fails++;
            $display("FAIL timeout_state: err=%b busy=%b out_valid=%b seen=%b required 1 0 0 0",
                     m_if.err_timeout, m_if.busy, m_if.out_valid, ov_seen);
        end
        repeat (3) tick();
        tests++;
        if (m_if.err_timeout !== 1'b1) begin
            fails++; $display("FAIL timeout_sticky: err=%b required 1", m_if.err_timeout);
        end
        start_frame();
        tests++;
        if (m_if.err_timeout !== 1'b0 || m_if.win_req !== 1'b1) begin
            fails++; $display("FAIL timeout_clear: err=%b win_req=%b required 0/1", m_if.err_timeout, m_if.win_req);
        end
        m_if.abort = 1'b1;
        tick();
        m_if.abort = 1'b0;
        tests++;
        if (m_if.busy !== 1'b0 || m_if.win_req !== 1'b0) begin
            fails++; $display("FAIL abort_load: busy=%b win_req=%b required 0/0", m_if.busy, m_if.win_req);
        end
    endtask

    task automatic test_abort();
        int fd0;
        bit bad;
        fd0 = fd_cnt;
        start_frame();
        m_if.win_ack = 1'b1;
        tick();
        m_if.win_ack = 1'b0;
        m_if.go = 1'b1;
        tick();
        m_if.go = 1'b0;
        tests++;
        if (m_if.conv_start !== 1'b1 || m_if.win_req !== 1'b0 || m_if.win_col !== '0) begin
            fails++; $display("FAIL go_busy: start=%b req=%b col=%0d required 1 0 0", m_if.conv_start, m_if.win_req, m_if.win_col);
        end
        m_if.conv_done = 1'b1;
        m_if.conv_result = ACC_W'('h7FFFF);
        m_if.abort = 1'b1;
        tick();
        m_if.conv_done = 1'b0;
        m_if.abort = 1'b0;
        tests++;
        if (m_if.busy !== 1'b0 || m_if.conv_start !== 1'b0 || m_if.out_valid !== 1'b0 || m_if.err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL abort_run: busy=%b start=%b v=%b err=%b required 0 0 0 0",
                     m_if.busy, m_if.conv_start, m_if.out_valid, m_if.err_timeout);
        end
        bad = 1'b0;
        repeat (5) begin
            if (m_if.out_valid !== 1'b0 || m_if.frame_done !== 1'b0 || m_if.busy !== 1'b0) bad = 1'b1;
            tick();
        end
        tests++;
        if (bad || fd_cnt !== fd0) begin
            fails++; $display("FAIL abort_quiet: activity=%b frame_done pulses=%0d required 0/0", bad, fd_cnt - fd0);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) frame_vals[k] = rand_acc();
        start_frame();
        do_pixel(0, 0, frame_vals[0], 0, 5, 0);
        do_pixel(0, 1, frame_vals[1], 0, 5, 0);
        tests++;
        if (m_if.win_req !== 1'b1 || m_if.win_row !== CNT_W'(1) || m_if.win_col !== '0) begin
            fails++; $display("FAIL mid_tag: req=%b tag=(%0d,%0d) required 1 (1,0)", m_if.win_req, m_if.win_row, m_if.win_col);
        end
        m_if.win_ack = 1'b1;
        tick();
        m_if.win_ack = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({m_if.win_req, m_if.conv_start, m_if.out_valid, m_if.busy, m_if.frame_done, m_if.err_timeout,
             m_if.win_row, m_if.win_col, m_if.out_row, m_if.out_col, m_if.out_data} !== '0) begin
            fails++; $display("FAIL mid_reset: busy=%b start=%b row=%0d required all outputs 0",
                              m_if.busy, m_if.conv_start, m_if.win_row);
        end
        run_frame(1'b1, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) frame_vals[k] = rand_acc();
            run_frame(1'b1, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        m_if.go = 0; m_if.abort = 0; m_if.win_ack = 0; m_if.conv_done = 0; m_if.conv_result = '0; m_if.out_ready = 0;
        n_if.go = 0; n_if.abort = 0; n_if.win_ack = 0; n_if.conv_done = 0; n_if.conv_result = '0; n_if.out_ready = 0;
        test_reset();
        test_frame();
        test_requant();
        test_relu_bypass();
        test_backpressure();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
